// File: rtl/mxint8_op_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mxint8_op_sched_pkg
// Description : Shared constants for the MXINT8 operation scheduler. Holds
//               the element width, block size, opcode width, the opcode
//               encodings and the requester count used by every file of
//               the block.
// Revision    : 1.0 - initial release
// ============================================================================
package mxint8_op_sched_pkg;

    localparam int MXINT8_ELEMENT_WIDTH = 8;
    localparam int BLOCK_SIZE           = 32;
    localparam int OPCODE_WIDTH         = 2;

    // Flattened width of one block of elements
    localparam int BLOCK_WIDTH = BLOCK_SIZE * MXINT8_ELEMENT_WIDTH;

    // Number of requesters sharing the datapath
    localparam int NUM_REQ = 2;

    // Opcode encodings
    localparam logic [OPCODE_WIDTH-1:0] OP_PASS = 2'b00;
    localparam logic [OPCODE_WIDTH-1:0] OP_NEG  = 2'b01;
    localparam logic [OPCODE_WIDTH-1:0] OP_ABS  = 2'b10;
    localparam logic [OPCODE_WIDTH-1:0] OP_RSVD = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mxint8_negate.sv
`default_nettype none
// ============================================================================
// Module      : mxint8_negate
// Description : Element-wise two's-complement negation of one MXINT8 block.
//               Results wrap modulo 256, so 0x80 maps to itself.
// Ports       : i_block - BLOCK_SIZE packed 8-bit elements
//               o_block - negated elements, same packing
// Revision    : 1.0 - initial release
// ============================================================================
module mxint8_negate
    import mxint8_op_sched_pkg::*;
(
    input  logic [BLOCK_WIDTH-1:0] i_block,
    output logic [BLOCK_WIDTH-1:0] o_block
);

    for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_elem
        assign o_block[i*MXINT8_ELEMENT_WIDTH +: MXINT8_ELEMENT_WIDTH] =
            ~i_block[i*MXINT8_ELEMENT_WIDTH +: MXINT8_ELEMENT_WIDTH] + 8'd1;
    end

endmodule
`default_nettype wire

// File: rtl/mxint8_op_sched.sv
`default_nettype none
// ============================================================================
// Module      : mxint8_op_sched
// Description : Two-requester scheduler for MXINT8 block operations
//               (PASS / NEG / ABS). A round-robin arbiter grants one
//               requester into a single registered output slot; the
//               result appears one cycle after accept and the slot can
//               drain and refill in the same cycle.
// Ports       : i_clk, i_rst_n      - clock, async active-low reset
//               i_req_valid/o_req_ready - per-requester handshake
//               i_req_opcode/scale/elements - per-requester payload
//               o_res_valid/i_res_ready - result handshake
//               o_res_tag/scale/elements/err - registered result
// Revision    : 1.0 - initial release
// ============================================================================
module mxint8_op_sched
    import mxint8_op_sched_pkg::*;
(
    input  logic                                    i_clk,
    input  logic                                    i_rst_n,
    input  logic [NUM_REQ-1:0]                      i_req_valid,
    output logic [NUM_REQ-1:0]                      o_req_ready,
    input  logic [NUM_REQ*OPCODE_WIDTH-1:0]         i_req_opcode,
    input  logic [NUM_REQ*MXINT8_ELEMENT_WIDTH-1:0] i_req_scale,
    input  logic [NUM_REQ*BLOCK_WIDTH-1:0]          i_req_elements,
    output logic                                    o_res_valid,
    input  logic                                    i_res_ready,
    output logic                                    o_res_tag,
    output logic [MXINT8_ELEMENT_WIDTH-1:0]         o_res_scale,
    output logic [BLOCK_WIDTH-1:0]                  o_res_elements,
    output logic                                    o_res_err
);

    localparam int W = MXINT8_ELEMENT_WIDTH;

    // Output-slot state encoding
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic                    r_ptr;
    logic                    r_res_tag;
    logic [W-1:0]            r_res_scale;
    logic [BLOCK_WIDTH-1:0]  r_res_elements;
    logic                    r_res_err;

    logic                    w_drain;
    logic                    w_slot_free;
    logic [NUM_REQ-1:0]      w_req_ready;
    logic                    w_accept;
    logic                    w_grant_idx;
    logic [OPCODE_WIDTH-1:0] w_grant_opcode;
    logic [W-1:0]            w_grant_scale;
    logic [BLOCK_WIDTH-1:0]  w_grant_elements;
    logic [BLOCK_WIDTH-1:0]  w_neg_elements;
    logic [BLOCK_WIDTH-1:0]  w_res_elements;

    assign w_drain     = (r_state == ST_FULL) && i_res_ready;
    assign w_slot_free = (r_state == ST_EMPTY) || w_drain;

    // Arbiter: a lone request wins outright; on contention the pointer
    // decides. Reset is folded in so no grant can leak while held in reset.
    always_comb begin
        w_req_ready = '0;
        if (i_rst_n && w_slot_free) begin
            case (i_req_valid)
                2'b01:   w_req_ready = 2'b01;
                2'b10:   w_req_ready = 2'b10;
                2'b11:   w_req_ready = r_ptr ? 2'b10 : 2'b01;
                default: w_req_ready = 2'b00;
            endcase
        end
    end

    assign o_req_ready = w_req_ready;
    assign w_accept    = |w_req_ready;
    assign w_grant_idx = w_req_ready[1];

    // Payload mux: only the granted block reaches the shared datapath
    assign w_grant_opcode   = w_grant_idx ? i_req_opcode[2*OPCODE_WIDTH-1:OPCODE_WIDTH]
                                          : i_req_opcode[OPCODE_WIDTH-1:0];
    assign w_grant_scale    = w_grant_idx ? i_req_scale[2*W-1:W] : i_req_scale[W-1:0];
    assign w_grant_elements = w_grant_idx ? i_req_elements[2*BLOCK_WIDTH-1:BLOCK_WIDTH]
                                          : i_req_elements[BLOCK_WIDTH-1:0];

    mxint8_negate u_negate (
        .i_block (w_grant_elements),
        .o_block (w_neg_elements)
    );

    // ABS picks the negated value only for negative elements; the reserved
    // opcode falls through to PASS.
    for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_op
        assign w_res_elements[i*W +: W] =
            ((w_grant_opcode == OP_NEG) ||
             ((w_grant_opcode == OP_ABS) && w_grant_elements[i*W + W - 1]))
                ? w_neg_elements[i*W +: W]
                : w_grant_elements[i*W +: W];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (w_drain && !w_accept) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_EMPTY;
            r_ptr          <= 1'b0;
            r_res_tag      <= 1'b0;
            r_res_scale    <= '0;
            r_res_elements <= '0;
            r_res_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ptr          <= ~w_grant_idx;
                r_res_tag      <= w_grant_idx;
                r_res_scale    <= w_grant_scale;
                r_res_elements <= w_res_elements;
                r_res_err      <= (w_grant_opcode == OP_RSVD);
            end
        end
    end

    assign o_res_valid    = (r_state == ST_FULL);
    assign o_res_tag      = r_res_tag;
    assign o_res_scale    = r_res_scale;
    assign o_res_elements = r_res_elements;
    assign o_res_err      = r_res_err;

endmodule
`default_nettype wire

// File: doc/mxint8_op_sched.md
MXINT8_OP_SCHED -- requirements
Module: mxint8_op_sched

Interface
REQ-001 Constants SHALL come from mxint8_includes.v: MXINT8_ELEMENT_WIDTH (8, element width in bits); BLOCK_SIZE (32, elements per block); OPCODE_WIDTH (2, opcode width in bits).
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_req_valid  input  2  per-requester request valid; bit n is requester n.
REQ-005 o_req_ready  output  2  per-requester accept; at most one bit SHALL be high in any cycle.
REQ-006 i_req_opcode  input  2x2  per-requester opcode: 00 PASS, 01 NEG, 10 ABS, 11 reserved.
REQ-007 i_req_scale  input  2x8  per-requester shared E8M0 block scale.
REQ-008 i_req_elements  input  2 x BLOCK_SIZE x 8  per-requester MXINT8 elements.
REQ-009 o_res_valid  output  1  result valid.
REQ-010 i_res_ready  input  1  downstream accept.
REQ-011 o_res_tag  output  1  index of the requester that owns the result.
REQ-012 o_res_scale  output  8  scale, passed through unchanged.
REQ-013 o_res_elements  output  BLOCK_SIZE x 8  result elements.
REQ-014 o_res_err  output  1  high when the result came from a reserved opcode.

Function
REQ-015 A transfer on either side SHALL occur only when valid and ready are both high in the same cycle.
REQ-016 Output-slot states SHALL be EMPTY and FULL; o_res_valid SHALL equal (state == FULL).
REQ-017 slot_free SHALL be (state == EMPTY) or (i_res_ready and o_res_valid).
REQ-018 Grant: when slot_free and only one i_req_valid bit is high, that requester SHALL be readied.
REQ-019 Grant: when slot_free and both bits are high, the requester named by the 1-bit priority pointer SHALL be readied.
REQ-020 After each accepted request, the priority pointer SHALL point to the requester that was not granted.
REQ-021 o_req_ready SHALL be combinational from i_req_valid, state, i_res_ready and the pointer; it SHALL be all-zero when slot_free is low.
REQ-022 Transitions: EMPTY->FULL on accept; FULL->EMPTY on drain with no accept; FULL->FULL on drain plus accept in the same cycle; FULL holds when i_res_ready is low.
REQ-023 Latency SHALL be one cycle from accept to o_res_valid, with throughput of one block per cycle under continuous ready.
REQ-024 Opcodes: PASS outputs e; NEG outputs two's-complement -e mod 256; ABS outputs e if e[7]==0, else -e.
REQ-025 -128 (0x80) SHALL wrap to 0x80 under both NEG and ABS, with no saturation and no flag.
REQ-026 A reserved opcode SHALL behave as PASS and SHALL set o_res_err for that result only.
REQ-027 All o_res_* outputs SHALL be registered and SHALL stay stable while o_res_valid is high and i_res_ready is low.
REQ-028 Requester inputs are sampled only in the accept cycle; later changes SHALL NOT affect the held result.

Reset
REQ-029 While i_rst_n is low: state SHALL be EMPTY, priority pointer 0, o_res_valid 0, and o_res_tag, o_res_scale, o_res_elements and o_res_err all 0.
REQ-030 While i_rst_n is low, o_req_ready SHALL be 0.
REQ-031 Assertion mid-transfer SHALL discard any held result with no partial output.
REQ-032 The first request accept SHALL be possible in the first clock edge after deassertion.

Structure
REQ-033 OPCODE_WIDTH and the opcode encodings SHALL be defined in mxint8_includes.v next to the existing constants.
REQ-034 Negation SHALL use one instance of mxint8_negate on the muxed granted block, not per-requester copies.
REQ-035 ABS selection, the arbiter and the slot FSM SHALL be local logic in this module.

Verification
REQ-036 Single request: req0 valid with NEG, scale 0x7F, elements all 0x05 -> next cycle o_res_valid=1, tag 0, elements all 0xFB, scale 0x7F, err 0.
REQ-037 Contention: both requesters valid continuously, i_res_ready=1 -> grants alternate 0,1,0,1 and one result per cycle.
REQ-038 Backpressure: i_res_ready=0 for 5 cycles while FULL -> o_req_ready=00 and outputs unchanged; first cycle with ready=1 drains and accepts the next request in the same cycle.
REQ-039 Boundary values: ABS on elements {0x80, 0x81, 0x00, 0x7F} -> {0x80, 0x7F, 0x00, 0x7F}; NEG on 0x80 -> 0x80.
REQ-040 Reserved opcode 11 with elements 0x3C -> output 0x3C with err=1; the next PASS result has err=0.
REQ-041 Reset assertion while FULL and stalled -> o_res_valid drops immediately (asynchronously), and after release the pointer favours req0 when both requesters are valid.
